// File: rtl/branch_predict_unit_if.sv
// Signal bundle between the fetch/EX pipeline and branch_predict_unit.
// master: pipeline side (drives fetch PC and EX fields).
// slave : the predictor/resolver (drives prediction, redirect and halt state).
interface branch_predict_unit_if #(
   parameter int PC_W = 9
);
   // Fetch-stage lookup
   logic [PC_W-1:0] fetch_pc;
   logic            pred_taken;
   logic [PC_W-1:0] pred_target;

   // EX-stage instruction
   logic            ex_valid;
   logic [PC_W-1:0] ex_pc;
   logic [31:0]     ex_imm;
   logic            ex_branch;
   logic [31:0]     ex_alu_result;
   logic            ex_jalr;
   logic            ex_halt;
   logic            ex_pred_taken;
   logic [PC_W-1:0] ex_pred_target;

   // Resolution results
   logic [31:0]     pc_four;
   logic [31:0]     pc_imm;
   logic            redirect;
   logic [31:0]     redirect_pc;
   logic            flush;
   logic            halted;

   modport master (
      output fetch_pc, ex_valid, ex_pc, ex_imm, ex_branch, ex_alu_result,
             ex_jalr, ex_halt, ex_pred_taken, ex_pred_target,
      input  pred_taken, pred_target, pc_four, pc_imm, redirect,
             redirect_pc, flush, halted
   );

   modport slave (
      input  fetch_pc, ex_valid, ex_pc, ex_imm, ex_branch, ex_alu_result,
             ex_jalr, ex_halt, ex_pred_taken, ex_pred_target,
      output pred_taken, pred_target, pc_four, pc_imm, redirect,
             redirect_pc, flush, halted
   );
endinterface

// File: rtl/branch_predict_unit.sv
// Branch predict unit: direct-mapped branch target table with 2-bit
// saturating counters for fetch prediction, plus EX-stage resolution of
// branch/JAL/JALR/halt that drives the PC redirect and pipeline flush.
// A retired halt parks the unit in a sticky HALTED state until reset.
// Optional macro BRU_STATS_EN adds branch/mispredict event counters.
module branch_predict_unit #(
   parameter int         PC_W     = 9,
   parameter int         IDX_W    = 4,
   parameter logic [1:0] CNT_INIT = 2'b01
) (
   input logic                  clk,
   input logic                  reset_n,
   branch_predict_unit_if.slave bus
`ifdef BRU_STATS_EN
   ,
   output logic [31:0]          stat_branches,
   output logic [31:0]          stat_mispredicts
`endif
);

   localparam int N     = 1 << IDX_W;
   localparam int TAG_W = PC_W - IDX_W - 2;

   typedef enum logic {ST_RUN, ST_HALTED} state_e;

   state_e          state_q, state_d;
   logic [PC_W-1:0] halt_pc_q, halt_pc_d;

   // Table storage: valid/counter are reset, tag/target are payload only.
   logic [N-1:0]     valid_q;
   logic [1:0]       cnt_q [N];
   logic [TAG_W-1:0] tag_q [N];
   logic [PC_W-1:0]  tgt_q [N];

   logic [IDX_W-1:0] f_idx;
   logic [TAG_W-1:0] f_tag;
   logic             f_hit;

   logic [31:0] ex_pc_ext, pc_four, pc_imm, target, redirect_pc;
   logic        taken, mispredict, run_ex, upd_en, redirect;

   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   logic             u_hit;
   logic [1:0]       u_cnt_d;
   logic [PC_W-1:0]  u_tgt_d;
   logic             u_tgt_we;

   // Fetch lookup: always reads the pre-update table contents.
   always_comb begin
      f_idx           = bus.fetch_pc[IDX_W+1:2];
      f_tag           = bus.fetch_pc[PC_W-1:IDX_W+2];
      f_hit           = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
      bus.pred_taken  = (state_q == ST_RUN) && f_hit && cnt_q[f_idx][1];
      bus.pred_target = tgt_q[f_idx];
   end

   // EX resolution: outcome, target, mispredict and redirect.
   always_comb begin
      // NOTE: every output gets a default up front so no path can infer a latch.
      redirect    = 1'b0;
      ex_pc_ext   = {{(32-PC_W){1'b0}}, bus.ex_pc};
      pc_four     = ex_pc_ext + 32'd4;
      pc_imm      = ex_pc_ext + bus.ex_imm;
      taken       = bus.ex_jalr | (bus.ex_branch & bus.ex_alu_result[0]);
      target      = bus.ex_jalr ? bus.ex_alu_result : pc_imm;
      mispredict  = (taken != bus.ex_pred_taken) |
                    (taken & (target[PC_W-1:0] != bus.ex_pred_target));
      run_ex      = (state_q == ST_RUN) & bus.ex_valid;
      upd_en      = run_ex & ~bus.ex_halt & (bus.ex_branch | bus.ex_jalr);
      redirect_pc = bus.ex_halt ? ex_pc_ext : (taken ? target : pc_four);

      if (state_q == ST_HALTED) begin
         redirect    = 1'b1;
         redirect_pc = {{(32-PC_W){1'b0}}, halt_pc_q};
      end else if (bus.ex_valid) begin
         redirect = mispredict | bus.ex_halt;
      end

      bus.pc_four     = pc_four;
      bus.pc_imm      = pc_imm;
      bus.redirect    = redirect;
      bus.redirect_pc = redirect_pc;
      bus.flush       = redirect;
      bus.halted      = (state_q == ST_HALTED);
   end

   // Next contents of the table entry addressed by the EX instruction.
   always_comb begin
      u_idx    = bus.ex_pc[IDX_W+1:2];
      u_tag    = bus.ex_pc[PC_W-1:IDX_W+2];
      u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
      u_cnt_d  = cnt_q[u_idx];
      u_tgt_d  = target[PC_W-1:0];
      u_tgt_we = taken;
      if (u_hit) begin
         if (taken) begin
            u_cnt_d = (cnt_q[u_idx] == 2'b11) ? 2'b11 : cnt_q[u_idx] + 2'd1;
         end else begin
            u_cnt_d = (cnt_q[u_idx] == 2'b00) ? 2'b00 : cnt_q[u_idx] - 2'd1;
         end
      end else begin
         u_cnt_d  = taken ? 2'b10 : CNT_INIT;
         u_tgt_we = 1'b1;
         u_tgt_d  = taken ? target[PC_W-1:0] : pc_four[PC_W-1:0];
      end
   end

   // Run/halt FSM next state; halt_pc captured on the halting edge.
   always_comb begin
      state_d   = state_q;
      halt_pc_d = halt_pc_q;
      if ((state_q == ST_RUN) && bus.ex_valid && bus.ex_halt) begin
         state_d   = ST_HALTED;
         halt_pc_d = bus.ex_pc;
      end
   end

   // Run/halt FSM registers; HALTED is left only through reset.
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      if (!reset_n) begin
         state_q   <= ST_RUN;
         halt_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         halt_pc_q <= halt_pc_d;
      end
   end

   // Valid bits and counters: cleared by reset, updated on resolved branches.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         valid_q <= '0;
         for (int i = 0; i < N; i++) cnt_q[i] <= CNT_INIT;
      end else if (upd_en) begin
         valid_q[u_idx] <= 1'b1;
         cnt_q[u_idx]   <= u_cnt_d;
      end
   end

   // Tag/target payload written alongside the valid/counter update.
   // NOTE: payload is meaningless while valid=0, so it has no reset and maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (upd_en) begin
         tag_q[u_idx] <= u_tag;
         if (u_tgt_we) tgt_q[u_idx] <= u_tgt_d;
      end
   end

`ifdef BRU_STATS_EN
   logic [31:0] stat_br_q, stat_br_d, stat_mp_q, stat_mp_d;

   // Event counters; both stop moving once HALTED since upd_en/run_ex drop.
   always_comb begin
      stat_br_d = stat_br_q + {31'd0, upd_en};
      stat_mp_d = stat_mp_q + {31'd0, run_ex & ~bus.ex_halt & mispredict};
   end

   // Event counter registers, wrapping modulo 2**32.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stat_br_q <= '0;
         stat_mp_q <= '0;
      end else begin
         stat_br_q <= stat_br_d;
         stat_mp_q <= stat_mp_d;
      end
   end

   assign stat_branches    = stat_br_q;
   assign stat_mispredicts = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// Self-checking bench for branch_predict_unit: a table of directed vectors
// with hand-computed expectations, plus hand-written reset sequences.
// Define BRU_STATS_EN to also check the statistics counters.
module tb_branch_predict_unit;

   logic clk = 1'b0;
   logic reset_n;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   branch_predict_unit_if #(.PC_W(9)) bus ();

`ifdef BRU_STATS_EN
   logic [31:0] stat_branches, stat_mispredicts;
`endif

   branch_predict_unit #(.PC_W(9), .IDX_W(4), .CNT_INIT(2'b01)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .bus              (bus.slave)
`ifdef BRU_STATS_EN
      ,
      .stat_branches    (stat_branches),
      .stat_mispredicts (stat_mispredicts)
`endif
   );

   typedef struct {
      logic [8:0]  fetch_pc;
      logic        ex_valid;
      logic [8:0]  ex_pc;
      logic [31:0] ex_imm;
      logic        ex_branch;
      logic [31:0] ex_alu;
      logic        ex_jalr;
      logic        ex_halt;
      logic        ex_pt;
      logic [8:0]  ex_ptgt;
      logic        e_pt;
      logic        chk_ptgt;
      logic [8:0]  e_ptgt;
      logic        e_redir;
      logic        chk_rpc;
      logic [31:0] e_rpc;
      logic        e_halted;
   } vec_t;

   vec_t vecs[18];

   function automatic vec_t mkv(
      input logic [8:0] fpc, input logic exv, input logic [8:0] expc,
      input logic [31:0] imm, input logic br, input logic [31:0] alu,
      input logic jalr, input logic halt, input logic ept, input logic [8:0] eptgt,
      input logic e_pt, input logic chk_ptgt, input logic [8:0] e_ptgt,
      input logic e_redir, input logic chk_rpc, input logic [31:0] e_rpc,
      input logic e_halted);
      vec_t v;
      v.fetch_pc = fpc;  v.ex_valid = exv; v.ex_pc = expc; v.ex_imm = imm;
      v.ex_branch = br;  v.ex_alu = alu;   v.ex_jalr = jalr; v.ex_halt = halt;
      v.ex_pt = ept;     v.ex_ptgt = eptgt;
      v.e_pt = e_pt;     v.chk_ptgt = chk_ptgt; v.e_ptgt = e_ptgt;
      v.e_redir = e_redir; v.chk_rpc = chk_rpc; v.e_rpc = e_rpc;
      v.e_halted = e_halted;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.fetch_pc       = v.fetch_pc;
      bus.ex_valid       = v.ex_valid;
      bus.ex_pc          = v.ex_pc;
      bus.ex_imm         = v.ex_imm;
      bus.ex_branch      = v.ex_branch;
      bus.ex_alu_result  = v.ex_alu;
      bus.ex_jalr        = v.ex_jalr;
      bus.ex_halt        = v.ex_halt;
      bus.ex_pred_taken  = v.ex_pt;
      bus.ex_pred_target = v.ex_ptgt;
   endtask

   task automatic idle(input logic [8:0] fpc);
      drive(mkv(fpc, 0, 9'h000, 0, 0, 0, 0, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 0));
   endtask

   initial begin
      //           fetch  exv ex_pc   imm          br alu         jr ht ept eptgt | ept ck ptgt  rd ck rpc      hlt
      vecs[0]  = mkv(9'h010, 0, 9'h000, 32'h0,        0, 32'h0,   0, 0, 0, 9'h000, 0, 0, 9'h000, 0, 0, 32'h0,   0);
      vecs[1]  = mkv(9'h010, 1, 9'h010, 32'h20,       1, 32'h1,   0, 0, 0, 9'h000, 0, 0, 9'h000, 1, 1, 32'h30,  0);
      vecs[2]  = mkv(9'h010, 1, 9'h010, 32'h20,       1, 32'h1,   0, 0, 1, 9'h030, 1, 1, 9'h030, 0, 0, 32'h0,   0);
      vecs[3]  = mkv(9'h010, 1, 9'h010, 32'h20,       1, 32'h1,   0, 0, 1, 9'h030, 1, 1, 9'h030, 0, 0, 32'h0,   0);
      vecs[4]  = mkv(9'h010, 1, 9'h010, 32'h20,       1, 32'h1,   0, 0, 1, 9'h030, 1, 1, 9'h030, 0, 0, 32'h0,   0);
      vecs[5]  = mkv(9'h010, 1, 9'h010, 32'h20,       1, 32'h0,   0, 0, 1, 9'h030, 1, 1, 9'h030, 1, 1, 32'h14,  0);
      vecs[6]  = mkv(9'h010, 0, 9'h000, 32'h0,        0, 32'h0,   0, 0, 0, 9'h000, 1, 1, 9'h030, 0, 0, 32'h0,   0);
      vecs[7]  = mkv(9'h010, 1, 9'h010, 32'h20,       1, 32'h0,   0, 0, 1, 9'h030, 1, 1, 9'h030, 1, 1, 32'h14,  0);
      vecs[8]  = mkv(9'h010, 0, 9'h000, 32'h0,        0, 32'h0,   0, 0, 0, 9'h000, 0, 0, 9'h000, 0, 0, 32'h0,   0);
      vecs[9]  = mkv(9'h040, 1, 9'h040, 32'h0,        0, 32'hA8,  1, 0, 1, 9'h0A4, 0, 0, 9'h000, 1, 1, 32'hA8,  0);
      vecs[10] = mkv(9'h040, 0, 9'h000, 32'h0,        0, 32'h0,   0, 0, 0, 9'h000, 1, 1, 9'h0A8, 0, 0, 32'h0,   0);
      vecs[11] = mkv(9'h000, 0, 9'h000, 32'h0,        0, 32'h0,   0, 0, 0, 9'h000, 0, 0, 9'h000, 0, 0, 32'h0,   0);
      vecs[12] = mkv(9'h1FC, 1, 9'h1FC, 32'hFFFFFFF0, 1, 32'h1,   0, 0, 0, 9'h000, 0, 0, 9'h000, 1, 1, 32'h1EC, 0);
      vecs[13] = mkv(9'h1FC, 0, 9'h000, 32'h0,        0, 32'h0,   0, 0, 0, 9'h000, 1, 1, 9'h1EC, 0, 0, 32'h0,   0);
      vecs[14] = mkv(9'h080, 1, 9'h080, 32'h0,        0, 32'h0,   0, 0, 1, 9'h000, 0, 0, 9'h000, 1, 1, 32'h84,  0);
      vecs[15] = mkv(9'h040, 1, 9'h050, 32'h20,       1, 32'h1,   0, 1, 0, 9'h000, 1, 1, 9'h0A8, 1, 1, 32'h50,  0);
      vecs[16] = mkv(9'h040, 1, 9'h040, 32'h0,        1, 32'h0,   0, 0, 1, 9'h0A8, 0, 0, 9'h000, 1, 1, 32'h50,  1);
      vecs[17] = mkv(9'h040, 1, 9'h090, 32'h0,        0, 32'h0,   0, 1, 0, 9'h000, 0, 0, 9'h000, 1, 1, 32'h50,  1);

      // Reset
      reset_n = 1'b0;
      idle(9'h010);
      repeat (2) @(negedge clk);
      check("reset halted", {31'd0, bus.halted}, 32'd0);
      reset_n = 1'b1;

      // Table-driven vectors: drive on negedge, check mid-low phase, commit on posedge.
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         drive(vecs[i]);
         #1;
         check($sformatf("v%0d pred_taken", i), {31'd0, bus.pred_taken}, {31'd0, vecs[i].e_pt});
         if (vecs[i].chk_ptgt)
            check($sformatf("v%0d pred_target", i), {23'd0, bus.pred_target}, {23'd0, vecs[i].e_ptgt});
         check($sformatf("v%0d redirect", i), {31'd0, bus.redirect}, {31'd0, vecs[i].e_redir});
         check($sformatf("v%0d flush", i), {31'd0, bus.flush}, {31'd0, vecs[i].e_redir});
         if (vecs[i].chk_rpc)
            check($sformatf("v%0d redirect_pc", i), bus.redirect_pc, vecs[i].e_rpc);
         check($sformatf("v%0d halted", i), {31'd0, bus.halted}, {31'd0, vecs[i].e_halted});
         if (!vecs[i].e_halted) begin
            check($sformatf("v%0d pc_four", i), bus.pc_four, {23'd0, vecs[i].ex_pc} + 32'd4);
            check($sformatf("v%0d pc_imm", i), bus.pc_imm, {23'd0, vecs[i].ex_pc} + vecs[i].ex_imm);
         end
      end

`ifdef BRU_STATS_EN
      // 8 table updates, 6 mispredicts before the halt; frozen afterwards.
      @(negedge clk);
      idle(9'h040);
      #1;
      check("stat_branches after halt", stat_branches, 32'd8);
      check("stat_mispredicts after halt", stat_mispredicts, 32'd6);
`endif

      // Async reset pulse while HALTED: state clears without a clock edge.
      @(negedge clk);
      idle(9'h040);
      #1;
      check("halted before reset pulse", {31'd0, bus.halted}, 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      check("async reset halted", {31'd0, bus.halted}, 32'd0);
      check("async reset redirect", {31'd0, bus.redirect}, 32'd0);
      check("async reset flush", {31'd0, bus.flush}, 32'd0);
`ifdef BRU_STATS_EN
      check("async reset stat_branches", stat_branches, 32'd0);
      check("async reset stat_mispredicts", stat_mispredicts, 32'd0);
`endif
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      check("table cleared 0x040", {31'd0, bus.pred_taken}, 32'd0);
      idle(9'h1FC);
      #1;
      check("table cleared 0x1FC", {31'd0, bus.pred_taken}, 32'd0);

      // Reset asserted before the edge drops the pending update.
      @(negedge clk);
      drive(mkv(9'h010, 1, 9'h010, 32'h20, 1, 32'h1, 0, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 0));
      #1;
      check("pending redirect", {31'd0, bus.redirect}, 32'd1);
      #2;
      reset_n = 1'b0;
      @(negedge clk);
      idle(9'h010);
      reset_n = 1'b1;
      #1;
      check("dropped update", {31'd0, bus.pred_taken}, 32'd0);

      // Same update without reset does allocate the entry.
      @(negedge clk);
      drive(mkv(9'h010, 1, 9'h010, 32'h20, 1, 32'h1, 0, 0, 0, 9'h000, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      idle(9'h010);
      #1;
      check("post-reset alloc pred_taken", {31'd0, bus.pred_taken}, 32'd1);
      check("post-reset alloc pred_target", {23'd0, bus.pred_target}, 32'h30);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
